myproject_dense_acc: RTL
========================

# myproject_dense_acc

Downstream accumulation stage for the pipelined 8-bit × 7-bit weight multipliers in the dense layer. It consumes one signed 15-bit product per cycle and sums N_IN products into one neuron result. It then adds the neuron bias, rescales with an arithmetic right shift, optionally applies ReLU, and saturates. The result is held in an output register with a valid/ready handshake, and that register back-pressures the product stream.

## Interface
- PROD_WIDTH, 15: signed product width (the multiplier dout width)
- N_IN, 16: products per neuron, ≥ 2
- ACC_WIDTH, 20: accumulator width; must be ≥ PROD_WIDTH + clog2(N_IN) + 1
- BIAS_WIDTH, 16: signed bias width, ≤ ACC_WIDTH, on the same scale as the products
- OUT_WIDTH, 16: signed result width, < ACC_WIDTH
- SHIFT, 4: arithmetic right shift applied after the bias add, < ACC_WIDTH
- RELU, 1: 1 clamps negative results to 0
- ap_clk  in  1  clock; all state updates on the rising edge
- ap_rst_n  in  1  asynchronous reset, active-low
- ce  in  1  global clock enable shared with the multiplier pipeline
- acc_clr  in  1  synchronous abort of the current neuron
- prod_valid  in  1  prod carries a valid product
- prod  in  PROD_WIDTH  signed product
- in_ready  out  1  a product can be accepted this cycle
- bias  in  BIAS_WIDTH  signed bias; sampled on the accepted last product
- res_valid  out  1  res_data holds a result
- res_ready  in  1  downstream accepts the result
- res_data  out  OUT_WIDTH  signed neuron result

## Operation
- Product transfer: `ce && prod_valid && in_ready`. Output pop: `ce && res_valid && res_ready`. Nothing changes state when ce = 0.
- Counter cnt runs 0..N_IN-1. State is implied by cnt:
  - IDLE: cnt = 0
  - ACCUM: cnt ≥ 1
  - Output register full: res_valid = 1
- Product transfer with cnt = 0: acc ← sext(prod), cnt ← 1.
- Product transfer with 0 < cnt < N_IN-1: acc ← acc + sext(prod), modulo 2^ACC_WIDTH, cnt ← cnt + 1.
- Product transfer with cnt = N_IN-1 (last product):
  - s = acc + sext(prod) + sext(bias), computed at ACC_WIDTH+1 bits.
  - r = s >>> SHIFT, arithmetic shift, floor rounding.
  - If RELU = 1 and r < 0, then r = 0.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - res_data ← r, res_valid ← 1, cnt ← 0.
- in_ready = (cnt != N_IN-1) || !res_valid || res_ready. Only the last product of a neuron stalls on a held result. Earlier products keep flowing.
- Pop with no new last product in the same cycle: res_valid ← 0. res_data keeps its value.
- Pop and last-product transfer in the same cycle: res_valid stays 1 and res_data takes the new result (back-to-back output, no bubble).
- acc_clr with ce = 1: cnt ← 0 and acc ← 0.
  - Any product presented in that cycle is discarded; clear wins.
  - The output register and an output pop in the same cycle are unaffected.
- res_data and res_valid are stable while res_valid = 1 and no pop occurs.

## Timing
- Reset values (asynchronous, on ap_rst_n low): cnt = 0, acc = 0, res_valid = 0, res_data = 0. in_ready = 1 during and after reset.
- Reset mid-neuron discards the partial sum. The first product after release starts a new neuron.
- Latency: the last product accepted at edge t gives res_valid = 1 and the final res_data after edge t.
- Throughput: one product per cycle, one result per N_IN cycles, with no stall when res_ready is held at 1.
- in_ready is combinational from cnt, res_valid and res_ready. It has no path from prod_valid, ce or acc_clr.
- ce low for k cycles delays every event by exactly k cycles and loses no data. This holds even if res_ready toggles while ce is low.

## Test plan
- Basic sum (N_IN=4, SHIFT=2, OUT_WIDTH=8, RELU=0): products 100, -20, 7, 1 with bias 12 → s = 100, res_data = 25. res_valid rises the cycle after the 4th product.
- Floor and ReLU (N_IN=4, SHIFT=2): products -3, -2, 0, 0 with bias 0 → RELU=0 gives -2; RELU=1 gives 0.
- Saturation (N_IN=4, SHIFT=2, OUT_WIDTH=8): four products of 16383 → 127. Four products of -16384 with RELU=0 → -128.
- Backpressure, default parameters:
  - Hold res_ready = 0 after the first result; the next 15 products are accepted.
  - in_ready = 0 at cnt = 15 until res_ready = 1.
  - On that cycle, pop and load happen together and res_valid stays 1.
- ce and clear:
  - Drop ce for 3 cycles mid-neuron → result identical and delayed exactly 3 cycles.
  - Assert acc_clr together with a valid product at cnt = 5 → that product is discarded. The next 16 products form the next result.
- Reset mid-operation: assert ap_rst_n low asynchronously at cnt = 9 → all outputs are 0 immediately. After release the next 16 products give a correct result.

Source files
------------

// File: rtl/myproject_dense_acc.sv
// myproject_dense_acc: accumulates N_IN signed products per neuron, adds bias, shifts, optional ReLU, saturates into a valid/ready output register
module myproject_dense_acc #(
    parameter int PROD_WIDTH = 15,
    parameter int N_IN       = 16,
    parameter int ACC_WIDTH  = 20,
    parameter int BIAS_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 4,
    parameter int RELU       = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         acc_clr,
    input  logic                         prod_valid,
    input  logic signed [PROD_WIDTH-1:0] prod,
    output logic                         in_ready,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [OUT_WIDTH-1:0]  res_data
);
    localparam int CW = $clog2(N_IN);
    localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

    logic [CW-1:0]               cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH:0]   sum, shr, rl;
    logic signed [OUT_WIDTH-1:0] sat;
    logic                        last, xfer, pop;

    assign last     = cnt == CW'(N_IN - 1);
    assign in_ready = !last || !res_valid || res_ready;
    assign xfer     = ce && prod_valid && in_ready && !acc_clr;
    assign pop      = ce && res_valid && res_ready;

    // Final sum is one bit wider than the accumulator so the bias add cannot wrap
    always_comb begin
        sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod) + (ACC_WIDTH+1)'(bias);
        shr = sum >>> SHIFT;
        rl  = (RELU != 0 && shr < 0) ? '0 : shr;
        sat = rl > MAXV ? MAXV[OUT_WIDTH-1:0] : rl < MINV ? MINV[OUT_WIDTH-1:0] : rl[OUT_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (ce) begin
            if (acc_clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (xfer) begin
                acc <= (cnt == '0 ? '0 : acc) + ACC_WIDTH'(prod);
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (xfer && last) begin
                res_valid <= 1'b1;
                res_data  <= sat;
            end else if (pop) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule
